exc_commit_ctrl: RTL and testbench

//  Exception/interrupt commit sequencer at the M stage, between the pipeline and CP0.

---
 rtl/exc_commit_ctrl_if.sv | 45 ++++
 rtl/exc_commit_ctrl.sv | 143 ++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// rtl/exc_commit_ctrl_if.sv - pipeline/CP0/fetch signal bundle for the exception commit sequencer
//
// Purpose: groups every non-clock, non-reset signal of exc_commit_ctrl.
// Modports:
//   slave  - the sequencer: takes M/E stage state, CP0 request/EPC and fetch ready;
//            drives the gated CP0 controls, victim PC/BD, flush and the PC redirect.
//   master - the surrounding pipeline/CP0/fetch side (opposite directions).
interface exc_commit_ctrl_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic        m_eret;
  logic        m_mtc0;
  logic        e_valid;
  logic [31:0] e_pc;
  logic        e_bd;
  logic        cp0_req;
  logic [31:0] cp0_epc;
  logic        redirect_ready;

  logic [29:0] cp0_pc;
  logic [4:0]  cp0_exc;
  logic        cp0_bd;
  logic        cp0_we;
  logic        cp0_exlclr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport slave (
    input  m_valid, m_pc, m_bd, m_exc, m_eret, m_mtc0,
    input  e_valid, e_pc, e_bd, cp0_req, cp0_epc, redirect_ready,
    output cp0_pc, cp0_exc, cp0_bd, cp0_we, cp0_exlclr,
    output flush, redirect_valid, redirect_pc, busy
  );

  modport master (
    output m_valid, m_pc, m_bd, m_exc, m_eret, m_mtc0,
    output e_valid, e_pc, e_bd, cp0_req, cp0_epc, redirect_ready,
    input  cp0_pc, cp0_exc, cp0_bd, cp0_we, cp0_exlclr,
    input  flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - M-stage exception/interrupt commit sequencer between pipeline and CP0
//
// Purpose: gates M-stage exception codes, MTC0 writes and ERET into CP0, supplies
// CP0 with the precise victim PC/BD (even when M holds a bubble), and on an
// interrupt/exception request or ERET flushes the pipeline, drains for
// DRAIN_CYCLES cycles, then holds a PC redirect until fetch accepts it.
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   bus (slave) - M/E stage state, CP0 request/EPC, fetch ready in;
//                 cp0_pc/exc/bd/we/exlclr, flush, redirect_valid/pc, busy out
module exc_commit_ctrl #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  exc_commit_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      state_q,   state_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic [31:0] tgt_q,     tgt_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_bd_q, hold_bd_d;

  logic [31:0] victim_pc;
  logic        victim_bd;

  // Victim selection: the oldest real instruction still in flight. When both
  // M and E are bubbles, the last known victim is replayed from the hold regs
  // so CP0 always sees a precise PC/BD.
  always_comb begin
    victim_pc = hold_pc_q;
    victim_bd = hold_bd_q;
    if (bus.m_valid) begin
      victim_pc = bus.m_pc;
      victim_bd = bus.m_bd;
    end else if (bus.e_valid) begin
      victim_pc = bus.e_pc;
      victim_bd = bus.e_bd;
    end
    hold_pc_d = victim_pc;
    hold_bd_d = victim_bd;
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    tgt_d              = tgt_q;
    bus.cp0_pc         = victim_pc[31:2];
    bus.cp0_bd         = victim_bd;
    bus.cp0_exc        = 5'd0;
    bus.cp0_we         = 1'b0;
    bus.cp0_exlclr     = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.busy           = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        bus.cp0_exc = bus.m_valid ? bus.m_exc : 5'd0;
        // An interrupt/exception taken this cycle cancels the M instruction,
        // so its MTC0 must not commit.
        bus.cp0_we  = bus.m_valid & bus.m_mtc0 & ~bus.cp0_req;
        if (bus.cp0_req) begin
          // CP0 request wins over a coincident ERET: EXL stays set.
          bus.flush = 1'b1;
          tgt_d     = HANDLER_PC;
          cnt_d     = DRAIN_INIT;
          state_d   = S_DRAIN;
        end else if (bus.m_valid & bus.m_eret) begin
          bus.cp0_exlclr = 1'b1;
          bus.flush      = 1'b1;
          tgt_d          = bus.cp0_epc;
          cnt_d          = DRAIN_INIT;
          state_d        = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.flush = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        // Exit is decided on the value before decrement, so DRAIN lasts
        // exactly DRAIN_CYCLES cycles (and one cycle if loaded with 0).
        if (cnt_q <= 4'd1) begin
          state_d = S_REDIR;
        end
      end
      S_REDIR: begin
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt_q;
        if (bus.redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // While reset is asserted the block presents its reset image.
    if (reset) begin
      bus.cp0_pc         = RESET_PC[31:2];
      bus.cp0_bd         = 1'b0;
      bus.cp0_exc        = 5'd0;
      bus.cp0_we         = 1'b0;
      bus.cp0_exlclr     = 1'b0;
      bus.flush          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.busy           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      tgt_q     <= 32'd0;
      hold_pc_q <= RESET_PC;
      hold_bd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      hold_pc_q <= hold_pc_d;
      hold_bd_q <= hold_bd_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb/tb_exc_commit_ctrl.sv - directed self-checking bench for exc_commit_ctrl
module tb_exc_commit_ctrl;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  exc_commit_ctrl_if bus ();

  exc_commit_ctrl #(
    .HANDLER_PC   (32'h0000_4180),
    .RESET_PC     (32'h0000_3000),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic bubbles();
    bus.m_valid        = 1'b0;
    bus.m_pc           = 32'd0;
    bus.m_bd           = 1'b0;
    bus.m_exc          = 5'd0;
    bus.m_eret         = 1'b0;
    bus.m_mtc0         = 1'b0;
    bus.e_valid        = 1'b0;
    bus.e_pc           = 32'd0;
    bus.e_bd           = 1'b0;
    bus.cp0_req        = 1'b0;
    bus.cp0_epc        = 32'd0;
  endtask

  task automatic do_reset();
    bubbles();
    bus.redirect_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.cp0_pc !== 30'hC00) $display("FAIL rst_cp0_pc got=%0h exp=%0h", bus.cp0_pc, 30'hC00); else passed++;
    total++; if (bus.cp0_exc !== 5'd0) $display("FAIL rst_cp0_exc got=%0h exp=0", bus.cp0_exc); else passed++;
    total++; if ({bus.cp0_bd, bus.cp0_we, bus.cp0_exlclr, bus.flush, bus.redirect_valid, bus.busy} !== 6'b0)
      $display("FAIL rst_controls got=%b exp=000000", {bus.cp0_bd, bus.cp0_we, bus.cp0_exlclr, bus.flush, bus.redirect_valid, bus.busy});
    else passed++;
    total++; if (bus.redirect_pc !== 32'd0) $display("FAIL rst_redirect_pc got=%0h exp=0", bus.redirect_pc); else passed++;
  endtask

  task automatic test_exception();
    // T: real instruction in M with exception, CP0 requests
    bus.m_valid = 1'b1; bus.m_pc = 32'h3010; bus.m_exc = 5'd10; bus.cp0_req = 1'b1;
    bus.redirect_ready = 1'b1;
    settle();
    total++; if (bus.flush !== 1'b1) $display("FAIL exc_T_flush got=%b exp=1", bus.flush); else passed++;
    total++; if (bus.cp0_exc !== 5'd10) $display("FAIL exc_T_code got=%0d exp=10", bus.cp0_exc); else passed++;
    total++; if (bus.cp0_pc !== 30'hC04) $display("FAIL exc_T_cp0_pc got=%0h exp=c04", bus.cp0_pc); else passed++;
    total++; if (bus.redirect_valid !== 1'b0) $display("FAIL exc_T_rv got=%b exp=0", bus.redirect_valid); else passed++;
    tick();
    // T+1: bubbles, cp0_req kept high to show it is ignored in DRAIN
    bubbles(); bus.cp0_req = 1'b1;
    settle();
    total++; if ({bus.flush, bus.busy, bus.redirect_valid} !== 3'b110) $display("FAIL exc_T1_state got=%b exp=110", {bus.flush, bus.busy, bus.redirect_valid}); else passed++;
    total++; if (bus.cp0_pc !== 30'hC04) $display("FAIL exc_T1_hold_pc got=%0h exp=c04", bus.cp0_pc); else passed++;
    total++; if (bus.cp0_exc !== 5'd0) $display("FAIL exc_T1_code got=%0d exp=0", bus.cp0_exc); else passed++;
    tick();
    settle();
    total++; if ({bus.flush, bus.busy, bus.redirect_valid} !== 3'b110) $display("FAIL exc_T2_state got=%b exp=110", {bus.flush, bus.busy, bus.redirect_valid}); else passed++;
    tick();
    bus.cp0_req = 1'b0;
    settle();
    total++; if ({bus.flush, bus.busy, bus.redirect_valid} !== 3'b111) $display("FAIL exc_T3_state got=%b exp=111", {bus.flush, bus.busy, bus.redirect_valid}); else passed++;
    total++; if (bus.redirect_pc !== 32'h4180) $display("FAIL exc_T3_redirect_pc got=%0h exp=4180", bus.redirect_pc); else passed++;
    tick();
    settle();
    total++; if ({bus.flush, bus.busy, bus.redirect_valid} !== 3'b000) $display("FAIL exc_T4_idle got=%b exp=000", {bus.flush, bus.busy, bus.redirect_valid}); else passed++;
  endtask

  task automatic test_e_bubble();
    bubbles();
    bus.m_exc = 5'd5;
    bus.e_valid = 1'b1; bus.e_pc = 32'h3020; bus.e_bd = 1'b1; bus.cp0_req = 1'b1;
    settle();
    total++; if (bus.cp0_pc !== 30'hC08) $display("FAIL ebub_cp0_pc got=%0h exp=c08", bus.cp0_pc); else passed++;
    total++; if (bus.cp0_bd !== 1'b1) $display("FAIL ebub_cp0_bd got=%b exp=1", bus.cp0_bd); else passed++;
    total++; if (bus.cp0_exc !== 5'd0) $display("FAIL ebub_exc_gated got=%0d exp=0", bus.cp0_exc); else passed++;
    total++; if (bus.flush !== 1'b1) $display("FAIL ebub_flush got=%b exp=1", bus.flush); else passed++;
    tick();
    bubbles();
    settle();
    total++; if ({bus.cp0_pc, bus.cp0_bd} !== {30'hC08, 1'b1}) $display("FAIL ebub_hold got=%0h/%b exp=c08/1", bus.cp0_pc, bus.cp0_bd); else passed++;
    tick(); tick(); tick();
    settle();
    total++; if (bus.busy !== 1'b0) $display("FAIL ebub_done got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_eret();
    bubbles();
    bus.m_valid = 1'b1; bus.m_pc = 32'h3030; bus.m_eret = 1'b1; bus.cp0_epc = 32'h3040;
    settle();
    total++; if ({bus.cp0_exlclr, bus.flush} !== 2'b11) $display("FAIL eret_T got=%b exp=11", {bus.cp0_exlclr, bus.flush}); else passed++;
    tick();
    bubbles();
    bus.cp0_epc = 32'h5555;
    settle();
    total++; if (bus.cp0_exlclr !== 1'b0) $display("FAIL eret_T1_exlclr got=%b exp=0", bus.cp0_exlclr); else passed++;
    tick(); tick();
    settle();
    total++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h3040}) $display("FAIL eret_redirect got=%b/%0h exp=1/3040", bus.redirect_valid, bus.redirect_pc); else passed++;
    tick();
    settle();
    total++; if (bus.busy !== 1'b0) $display("FAIL eret_done got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_eret_vs_req();
    bubbles();
    bus.m_valid = 1'b1; bus.m_pc = 32'h3050; bus.m_eret = 1'b1; bus.cp0_epc = 32'h3040; bus.cp0_req = 1'b1;
    settle();
    total++; if ({bus.cp0_exlclr, bus.flush} !== 2'b01) $display("FAIL eretreq_T got=%b exp=01", {bus.cp0_exlclr, bus.flush}); else passed++;
    tick();
    bubbles();
    tick(); tick();
    settle();
    total++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h4180}) $display("FAIL eretreq_redirect got=%b/%0h exp=1/4180", bus.redirect_valid, bus.redirect_pc); else passed++;
    tick();
  endtask

  task automatic test_mtc0();
    bubbles();
    bus.m_valid = 1'b1; bus.m_pc = 32'h3060; bus.m_mtc0 = 1'b1;
    settle();
    total++; if (bus.cp0_we !== 1'b1) $display("FAIL mtc0_we got=%b exp=1", bus.cp0_we); else passed++;
    total++; if (bus.flush !== 1'b0) $display("FAIL mtc0_noflush got=%b exp=0", bus.flush); else passed++;
    tick();
    bus.cp0_req = 1'b1;
    settle();
    total++; if (bus.cp0_we !== 1'b0) $display("FAIL mtc0_req_we got=%b exp=0", bus.cp0_we); else passed++;
    tick();
    bus.cp0_req = 1'b0;
    settle();
    total++; if (bus.cp0_we !== 1'b0) $display("FAIL mtc0_drain_we got=%b exp=0", bus.cp0_we); else passed++;
    bubbles();
    tick(); tick(); tick();
    settle();
    total++; if (bus.busy !== 1'b0) $display("FAIL mtc0_done got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_stall_and_reset();
    bubbles();
    bus.redirect_ready = 1'b0;
    bus.m_valid = 1'b1; bus.m_pc = 32'h3070; bus.cp0_req = 1'b1;
    tick();
    bubbles();
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if ({bus.redirect_valid, bus.redirect_pc, bus.flush} !== {1'b1, 32'h4180, 1'b1})
        $display("FAIL stall_%0d got=%b/%0h/%b exp=1/4180/1", i, bus.redirect_valid, bus.redirect_pc, bus.flush);
      else passed++;
      tick();
    end
    reset = 1'b1;
    settle();
    total++; if ({bus.redirect_valid, bus.flush, bus.busy} !== 3'b000) $display("FAIL stall_in_reset got=%b exp=000", {bus.redirect_valid, bus.flush, bus.busy}); else passed++;
    tick();
    reset = 1'b0;
    bus.redirect_ready = 1'b1;
    settle();
    total++; if ({bus.redirect_valid, bus.flush, bus.busy} !== 3'b000) $display("FAIL stall_after_reset got=%b exp=000", {bus.redirect_valid, bus.flush, bus.busy}); else passed++;
    total++; if (bus.cp0_pc !== 30'hC00) $display("FAIL stall_after_reset_pc got=%0h exp=c00", bus.cp0_pc); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    bubbles();
    bus.redirect_ready = 1'b1;
    test_reset();
    test_exception();
    test_e_bubble();
    test_eret();
    test_eret_vs_req();
    test_mtc0();
    test_stall_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
